// File: rtl/param_seq_detect.sv
// Serial bit-pattern detector with a PAT_LEN-bit history window.
// Reports each match with a registered one-cycle pulse and keeps a
// saturating, clearable count of matches. Overlapping or non-overlapping
// detection is selected at elaboration time.
//
// Handshake: a bit on inp_bit is consumed on a rising edge only when
// in_valid=1; there is no back-pressure, so every valid bit is always taken.
module param_seq_detect #(
    parameter int unsigned        PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int unsigned        OVERLAP = 1,
    parameter int unsigned        CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inp_bit,
    input  logic               in_valid,
    input  logic               cnt_clr,
    output logic               seq_seen,
    output logic [CNT_W-1:0]   match_count,
    output logic [5:0]         fill,
    output logic               dbg_state,
    output logic [PAT_LEN-1:0] dbg_hist
);

    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } state_e;

    localparam logic [5:0]       FILL_FULL = 6'(PAT_LEN);
    localparam logic [5:0]       FILL_NEED = 6'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam bit               NO_OVL    = (OVERLAP == 0);

    state_e             state_q, state_d;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [5:0]         fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               seen_q, seen_d;

    logic [PAT_LEN-1:0] window;
    logic               match;
    logic               restart;
    logic [CNT_W-1:0]   cnt_base;

    // The candidate window is the newest PAT_LEN-1 history bits plus the bit on the wire.
    assign window  = {hist_q[PAT_LEN-2:0], inp_bit};
    assign match   = in_valid && (fill_q >= FILL_NEED) && (window == PATTERN);
    assign restart = match && NO_OVL;

    // Register all state; reset wins over every other input on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILLING;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
        end
    end

    // Next-state logic: fill only grows while FILLING; a non-overlapping match restarts.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        if (in_valid) begin
            if (restart) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = window;
                if (state_q == FILLING) begin
                    fill_d = fill_q + 6'd1;
                end
            end
        end
        case (state_q)
            FILLING: if (fill_d == FILL_FULL) state_d = ARMED;
            ARMED:   if (restart)             state_d = FILLING;
            default:                          state_d = FILLING;
        endcase
    end

    // Match counter: clear is applied first so a coincident match leaves a count of 1.
    always_comb begin
        cnt_base = cnt_clr ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (match && (cnt_base != CNT_MAX)) begin
            cnt_d = cnt_base + CNT_W'(1);
        end
        seen_d = match;
    end

    assign seq_seen    = seen_q;
    assign match_count = cnt_q;
    assign fill        = fill_q;
    assign dbg_state   = state_q;
    assign dbg_hist    = hist_q;

endmodule

// File: tb/tb_param_seq_detect.sv
// Directed bench for param_seq_detect. Three instances share one stimulus
// stream: defaults (overlapping), non-overlapping, and a 2-bit counter.
module tb_param_seq_detect;

    logic clk;
    logic reset;
    logic inp_bit;
    logic in_valid;
    logic cnt_clr;

    logic       a_seen, b_seen, c_seen;
    logic [7:0] a_cnt, b_cnt;
    logic [1:0] c_cnt;
    logic [5:0] a_fill, b_fill, c_fill;
    logic       a_state, b_state, c_state;
    logic [3:0] a_hist, b_hist, c_hist;

    int n_assert = 0;
    int n_fail   = 0;

    param_seq_detect u_ovl (
        .clk(clk), .reset(reset), .inp_bit(inp_bit), .in_valid(in_valid), .cnt_clr(cnt_clr),
        .seq_seen(a_seen), .match_count(a_cnt), .fill(a_fill), .dbg_state(a_state), .dbg_hist(a_hist)
    );

    param_seq_detect #(.OVERLAP(0)) u_novl (
        .clk(clk), .reset(reset), .inp_bit(inp_bit), .in_valid(in_valid), .cnt_clr(cnt_clr),
        .seq_seen(b_seen), .match_count(b_cnt), .fill(b_fill), .dbg_state(b_state), .dbg_hist(b_hist)
    );

    param_seq_detect #(.CNT_W(2)) u_c2 (
        .clk(clk), .reset(reset), .inp_bit(inp_bit), .in_valid(in_valid), .cnt_clr(cnt_clr),
        .seq_seen(c_seen), .match_count(c_cnt), .fill(c_fill), .dbg_state(c_state), .dbg_hist(c_hist)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change 1 time unit after an edge, outputs are sampled there too.
    task automatic cyc(input logic v, input logic b, input logic clr, input logic rst);
        in_valid = v;
        inp_bit  = b;
        cnt_clr  = clr;
        reset    = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        cyc(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        in_valid = 1'b0;
        inp_bit  = 1'b0;
        cnt_clr  = 1'b0;
        reset    = 1'b1;

        // Reset with a valid bit present: the bit must be discarded.
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_seen", 32'(a_seen), 0);
        chk("rst_cnt", 32'(a_cnt), 0);
        chk("rst_fill", 32'(a_fill), 0);
        chk("rst_hist", 32'(a_hist), 0);
        chk("rst_state", 32'(a_state), 0);
        idle();
        chk("rst_idle_fill", 32'(a_fill), 0);
        chk("rst_idle_seen", 32'(a_seen), 0);

        // Single match 1,0,1,1.
        send(1'b1);
        chk("m1_fill1", 32'(a_fill), 1);
        send(1'b0);
        chk("m1_fill2", 32'(a_fill), 2);
        send(1'b1);
        chk("m1_fill3", 32'(a_fill), 3);
        chk("m1_seen3", 32'(a_seen), 0);
        chk("m1_state3", 32'(a_state), 0);
        send(1'b1);
        chk("m1_seen_ovl", 32'(a_seen), 1);
        chk("m1_seen_novl", 32'(b_seen), 1);
        chk("m1_seen_c2", 32'(c_seen), 1);
        chk("m1_cnt_ovl", 32'(a_cnt), 1);
        chk("m1_cnt_novl", 32'(b_cnt), 1);
        chk("m1_fill_ovl", 32'(a_fill), 4);
        chk("m1_fill_novl", 32'(b_fill), 0);
        chk("m1_hist_ovl", 32'(a_hist), 32'hB);
        chk("m1_hist_novl", 32'(b_hist), 0);
        chk("m1_state_ovl", 32'(a_state), 1);
        chk("m1_state_novl", 32'(b_state), 0);
        idle();
        chk("m1_pulse_end", 32'(a_seen), 0);
        chk("m1_cnt_hold", 32'(a_cnt), 1);

        // Continue with 0,1,1 to form 1011011 (gap above holds everything).
        send(1'b0);
        chk("ov_hist_a", 32'(a_hist), 32'h6);
        chk("ov_seen_a", 32'(a_seen), 0);
        send(1'b1);
        chk("ov_seen_b", 32'(a_seen), 0);
        send(1'b1);
        chk("ov_seen_ovl", 32'(a_seen), 1);
        chk("ov_cnt_ovl", 32'(a_cnt), 2);
        chk("ov_seen_novl", 32'(b_seen), 0);
        chk("ov_cnt_novl", 32'(b_cnt), 1);
        chk("ov_fill_novl", 32'(b_fill), 3);
        chk("ov_cnt_c2", 32'(c_cnt), 2);
        idle();
        chk("ov_pulse_end", 32'(a_seen), 0);

        // Partial match across an in_valid gap.
        do_reset();
        chk("gap_rst_cnt", 32'(a_cnt), 0);
        send(1'b1);
        send(1'b0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("gap_fill_hold", 32'(a_fill), 2);
            chk("gap_seen", 32'(a_seen), 0);
        end
        send(1'b1);
        chk("gap_seen3", 32'(a_seen), 0);
        chk("gap_fill3", 32'(a_fill), 3);
        send(1'b1);
        chk("gap_seen_ovl", 32'(a_seen), 1);
        chk("gap_seen_novl", 32'(b_seen), 1);
        chk("gap_cnt", 32'(a_cnt), 1);

        // Reset mid-pattern discards progress.
        do_reset();
        send(1'b1);
        send(1'b0);
        send(1'b1);
        do_reset();
        chk("mid_rst_fill", 32'(a_fill), 0);
        chk("mid_rst_hist", 32'(a_hist), 0);
        chk("mid_rst_cnt", 32'(a_cnt), 0);
        send(1'b1);
        chk("mid_seen", 32'(a_seen), 0);
        chk("mid_seen_novl", 32'(b_seen), 0);
        chk("mid_fill", 32'(a_fill), 1);

        // 1011 five times: 2-bit counter saturates at 3.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send(1'b1);
            chk("sat_pulse_end", 32'(c_seen), 0);
            send(1'b0);
            send(1'b1);
            send(1'b1);
            chk("sat_seen_c2", 32'(c_seen), 1);
            chk("sat_cnt_c2", 32'(c_cnt), (k < 2) ? k + 1 : 3);
            chk("sat_cnt_ovl", 32'(a_cnt), k + 1);
            chk("sat_cnt_novl", 32'(b_cnt), k + 1);
        end

        // Clear coinciding with a match, then clear alone.
        send(1'b1);
        send(1'b0);
        send(1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("clr_match_c2", 32'(c_cnt), 1);
        chk("clr_match_ovl", 32'(a_cnt), 1);
        chk("clr_match_seen", 32'(c_seen), 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_only_c2", 32'(c_cnt), 0);
        chk("clr_only_ovl", 32'(a_cnt), 0);
        chk("clr_only_seen", 32'(c_seen), 0);
        chk("clr_fill_ovl", 32'(a_fill), 4);
        chk("clr_hist_ovl", 32'(a_hist), 32'hB);
        chk("clr_fill_novl", 32'(b_fill), 0);

        // Clear with a valid non-matching bit.
        send(1'b1);
        chk("pre_clr_cnt", 32'(a_cnt), 0);
        send(1'b0);
        send(1'b1);
        send(1'b1);
        chk("recount_ovl", 32'(a_cnt), 1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("clr_valid_cnt", 32'(a_cnt), 0);
        chk("clr_valid_hist", 32'(a_hist), 32'h6);

        // Reset has priority over cnt_clr and a valid bit.
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("prio_fill", 32'(a_fill), 0);
        chk("prio_state", 32'(a_state), 0);
        chk("prio_cnt", 32'(c_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
